// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants for the 7-segment display path
package seg7_pkg;

   localparam int MAX_DIGITS = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed digit scanner with blank gap and per-frame input snapshot
module seg7_scan #(
   parameter int NDIGIT     = 8,
   parameter int PRESCALE   = 1000,
   parameter int GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [4*NDIGIT-1:0]   value,
   input  logic [NDIGIT-1:0]     dp_mask,
   input  logic [NDIGIT-1:0]     blank_mask,
   output logic [3:0]            num,
   output logic                  dp,
   output logic [NDIGIT-1:0]     digit_sel,
   output logic                  frame_done
);
   import seg7_pkg::*;

   localparam int CW = $clog2(max2(PRESCALE, GAP_CYCLES) + 1);
   localparam int IW = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

   localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NDIGIT - 1);

   generate
      if (NDIGIT < 1 || NDIGIT > MAX_DIGITS || PRESCALE < 1 || GAP_CYCLES < 0) begin : g_bad_param
         $error("seg7_scan: parameter out of range");
      end
   endgenerate

   logic [1:0]          state;
   logic [IW-1:0]       idx;
   logic [CW-1:0]       cnt;
   logic [4*NDIGIT-1:0] snap_value;
   logic [NDIGIT-1:0]   snap_dp;
   logic [NDIGIT-1:0]   snap_blank;

   logic [1:0]          nxt_state;
   logic [IW-1:0]       nxt_idx;
   logic [CW-1:0]       nxt_cnt;
   logic                load;
   logic                wrap;
   logic                advance;

   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cnt   = cnt + 1'b1;
      load      = 1'b0;
      wrap      = 1'b0;
      advance   = 1'b0;

      case (state)
         ST_IDLE: begin
            nxt_cnt = '0;
            if (en) begin
               load      = 1'b1;
               nxt_state = ST_SHOW;
               nxt_idx   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt == SHOW_LAST) begin
               if (GAP_CYCLES > 0) begin
                  nxt_state = ST_GAP;
                  nxt_cnt   = '0;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (cnt == GAP_LAST) begin
               advance = 1'b1;
            end
         end
         default: begin
            nxt_state = ST_IDLE;
            nxt_idx   = '0;
            nxt_cnt   = '0;
         end
      endcase

      // The counter reloads on every boundary, so digit and frame periods never drift.
      if (advance) begin
         nxt_state = ST_SHOW;
         nxt_cnt   = '0;
         if (idx == IDX_LAST) begin
            nxt_idx = '0;
            load    = 1'b1;
            wrap    = 1'b1;
         end else begin
            nxt_idx = idx + 1'b1;
         end
      end

      if (!en) begin
         nxt_state = ST_IDLE;
         nxt_idx   = '0;
         nxt_cnt   = '0;
         load      = 1'b0;
         wrap      = 1'b0;
      end
   end

   logic [4*NDIGIT-1:0] nxt_value;
   logic [NDIGIT-1:0]   nxt_dp;
   logic [NDIGIT-1:0]   nxt_blank;

   assign nxt_value = load ? value      : snap_value;
   assign nxt_dp    = load ? dp_mask    : snap_dp;
   assign nxt_blank = load ? blank_mask : snap_blank;

   // Outputs are decoded from the next state so they line up with the state register.
   logic [NDIGIT-1:0] cur_onehot;
   logic [3:0]        cur_num;
   logic              cur_dp;
   logic              cur_blank;

   always_comb begin
      cur_onehot = '0;
      cur_num    = '0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      for (int i = 0; i < NDIGIT; i++) begin
         if (nxt_idx == IW'(i)) begin
            cur_onehot[i] = 1'b1;
            cur_num       = nxt_value[4*i +: 4];
            cur_dp        = nxt_dp[i];
            cur_blank     = nxt_blank[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         cnt        <= '0;
         snap_value <= '0;
         snap_dp    <= '0;
         snap_blank <= '0;
         num        <= '0;
         dp         <= 1'b0;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cnt        <= nxt_cnt;
         frame_done <= wrap;
         if (load) begin
            snap_value <= value;
            snap_dp    <= dp_mask;
            snap_blank <= blank_mask;
         end
         if (nxt_state == ST_SHOW) begin
            digit_sel <= cur_blank ? '0 : cur_onehot;
            num       <= cur_num;
            dp        <= cur_dp & ~cur_blank;
         end else begin
            digit_sel <= '0;
            dp        <= 1'b0;
         end
      end
   end

endmodule
